// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the execute stage and the ALU control decoder.
//   - ALU command encodings (same constants the control decoder emits)
//   - Occupancy state encoding of the execute-stage skid buffer
//   - Small helper to classify a command as legal / illegal
// -----------------------------------------------------------------------------
package alu_pkg;

    // ALU command encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Skid buffer occupancy: number of entries held (0, 1 or 2)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    // True when the command is one of the four operations the ALU implements
    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        return (cmd == ALU_AND) || (cmd == ALU_OR) ||
               (cmd == ALU_ADD) || (cmd == ALU_SUB);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
//   Purely combinational ALU used on the input side of the execute stage.
//
//   Ports
//     alucmd_i   [3:0]       ALU command (AND / OR / ADD / SUB)
//     op_a_i     [XLEN-1:0]  first operand
//     op_b_i     [XLEN-1:0]  second operand
//     result_o   [XLEN-1:0]  operation result (0 for an illegal command)
//     zero_o                 result_o == 0
//     illegal_o              alucmd_i is not one of the four legal codes
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      alucmd_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (alucmd_i)
            ALU_AND: result_o = op_a_i & op_b_i;
            ALU_OR:  result_o = op_a_i | op_b_i;
            // ADD/SUB wrap modulo 2^XLEN; carry-out is intentionally dropped
            ALU_ADD: result_o = op_a_i + op_b_i;
            ALU_SUB: result_o = op_a_i - op_b_i;
            default: begin
                // Unknown command still produces a well-defined entry so the
                // pipeline never drops it; the flag lets later stages trap.
                result_o  = '0;
                illegal_o = 1'b1;
            end
        endcase
    end

    // Zero flag is derived from the final result, so an illegal command
    // (result forced to 0) reports zero=1 as well.
    assign zero_o = (result_o == '0);

endmodule : alu_core

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Registered execute stage. The ALU result is computed combinationally from
//   the incoming operands and captured into a 2-entry skid buffer at the input
//   transfer, so upstream never sees a combinational path from out_ready.
//
//   Handshake (both sides): a transfer happens on a rising clk edge where
//   valid & ready are both 1. valid may not depend on ready; once valid is
//   raised the producer holds its data until the transfer. in_ready is a
//   register; out_* always show the buffer head and stay stable while
//   out_valid & !out_ready.
//
//   Ports
//     clk          clock, rising edge
//     rst          asynchronous active-low reset
//     in_valid     upstream presents an operation
//     in_ready     stage can accept (registered)
//     alucmd [3:0] ALU command
//     op_a, op_b   operands [XLEN-1:0]
//     in_tag       pass-through tag [TAGW-1:0]
//     out_valid    head entry is valid
//     out_ready    downstream accepts
//     out_result   head result [XLEN-1:0]
//     out_zero     head result is zero
//     out_illegal  head command was illegal
//     out_tag      head tag [TAGW-1:0]
//     dbg_state    occupancy state (EMPTY / ONE / FULL) for observation
// -----------------------------------------------------------------------------
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alucmd,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_illegal,
    output logic [TAGW-1:0] out_tag,
    output occ_state_e      dbg_state
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            illegal;
        logic [TAGW-1:0] tag;
    } entry_t;

    // -------------------------------------------------------------------------
    // Input-side ALU
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            alu_illegal;

    alu_core #(
        .XLEN (XLEN)
    ) u_alu_core (
        .alucmd_i  (alucmd),
        .op_a_i    (op_a),
        .op_b_i    (op_b),
        .result_o  (alu_result),
        .zero_o    (alu_zero),
        .illegal_o (alu_illegal)
    );

    entry_t new_entry;
    always_comb begin
        new_entry         = '0;
        new_entry.result  = alu_result;
        new_entry.zero    = alu_zero;
        new_entry.illegal = alu_illegal;
        new_entry.tag     = in_tag;
    end

    // -------------------------------------------------------------------------
    // Skid buffer state
    //   head_q holds the entry being presented; skid_q holds the second entry
    //   only in ST_FULL.
    // -------------------------------------------------------------------------
    occ_state_e state_q, state_d;
    entry_t     head_q,  head_d;
    entry_t     skid_q,  skid_d;
    logic       in_ready_q, in_ready_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state / datapath steering
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    head_d  = new_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                case ({in_fire, out_fire})
                    2'b10: begin
                        // Head is stalled: park the newcomer behind it
                        skid_d  = new_entry;
                        state_d = ST_FULL;
                    end
                    2'b01: begin
                        state_d = ST_EMPTY;
                    end
                    2'b11: begin
                        // Head leaves while the newcomer arrives
                        head_d  = new_entry;
                    end
                    default: begin
                        state_d = ST_ONE;
                    end
                endcase
            end
            ST_FULL: begin
                // in_ready is 0 here, so only the output side can move
                if (out_fire) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Registered ready: looks at where the buffer will be after this edge,
        // so a full buffer never accepts a third entry.
        in_ready_d = (state_d != ST_FULL);
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_result  = head_q.result;
    assign out_zero    = head_q.zero;
    assign out_illegal = head_q.illegal;
    assign out_tag     = head_q.tag;
    assign dbg_state   = state_q;

endmodule : alu_exec_stage

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage directly downstream of the ALU control decoder. It consumes the 4-bit ALU command together with two operands and produces the result, a zero flag for branch resolution, and a pass-through tag.
- Operand data enter through a valid/ready handshake and sit in a 2-entry skid buffer, so upstream and downstream stalls decouple without combinational ready paths.
- Sits between the decode/control stage and the memory/writeback stage.

Parameters:
- XLEN, 32, operand and result width in bits.
- TAGW, 5, width of the pass-through tag (destination register index).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; asserting rst=0 clears state immediately, release is synchronous to clk.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage can accept; registered output.
- alucmd  input  4  ALU command: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- op_a  input  XLEN  first operand.
- op_b  input  XLEN  second operand.
- in_tag  input  TAGW  tag carried with the operation.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- out_result  output  XLEN  ALU result.
- out_zero  output  1  1 when out_result == 0.
- out_illegal  output  1  alucmd was not one of the four legal codes.
- out_tag  output  TAGW  tag of the presented result.

Behaviour:
- Reset (rst=0, async) values: in_ready=0, out_valid=0, out_result=0, out_zero=0, out_illegal=0, out_tag=0, occupancy EMPTY.
- First rising clk after rst returns to 1: in_ready=1.
- An input transfer occurs on a rising edge where in_valid & in_ready.
- An output transfer occurs on a rising edge where out_valid & out_ready.
- ALU function is combinational on the input side; the result is captured at the input transfer. Latency is 1 cycle: a transfer at edge N gives out_valid=1 after edge N when the buffer was empty.
- Arithmetic rules:
  - AND/OR are bitwise.
  - ADD/SUB are modulo 2^XLEN; no carry or overflow output.
  - SUB is op_a - op_b in two's complement.
- Illegal alucmd: result=0, out_zero=1, out_illegal=1. The entry is still accepted and delivered, never dropped.
- Buffer occupancy FSM (states EMPTY, ONE, FULL):
  - EMPTY: on input transfer go to ONE.
  - ONE, input only: go to FULL.
  - ONE, output only: go to EMPTY.
  - ONE, both input and output: stay in ONE; the new entry becomes head.
  - FULL, output transfer: go to ONE, skid entry moves to head. No input is possible because in_ready=0.
- in_ready is registered. It is 0 in FULL, and 0 during reset and the first cycle after reset release; otherwise it is 1.
- out_valid = (state != EMPTY). out_* fields always show the head entry and are stable while out_valid & !out_ready.
- Ordering is strictly FIFO and tags are never reordered or duplicated.
- Reset mid-operation: all entries are discarded and the FSM goes to EMPTY; no partial output is presented.
- in_valid while in_ready=0 is ignored; upstream holds its data.

Decomposition:
- Shared package alu_pkg:
  - localparams ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110.
  - Occupancy state encodings ST_EMPTY/ST_ONE/ST_FULL.
  - The ALU control decoder uses the same command constants.
- Sub-module alu_core: purely combinational (alucmd, op_a, op_b -> result, zero, illegal). Instantiated once on the input side.
- alu_exec_stage contains only the skid buffer and the FSM.

Test Plan:
- Reset: hold rst=0 with in_valid=1 -> out_valid=0 and in_ready=0 throughout; in_ready=1 one cycle after release.
- Basic ops, out_ready=1, op_a=0x0000000F, op_b=0x00000005 with tags 1..4:
  - ADD -> 0x00000014, tag 1.
  - SUB -> 0x0000000A, tag 2.
  - AND -> 0x00000005, tag 3.
  - OR -> 0x0000000F, tag 4.
  - Each result appears one cycle after its accept.
- Wrap and zero flag:
  - ADD 0xFFFFFFFF+1 -> result 0, out_zero=1.
  - SUB 5-5 -> 0, out_zero=1.
  - SUB 0-1 -> 0xFFFFFFFF, out_zero=0.
- Backpressure: out_ready=0 and stream 3 ops -> two are accepted, in_ready drops to 0 after the second, out_* hold the first. Then out_ready=1 -> tags drain in order, the third op is accepted, no loss.
- Illegal command: alucmd=4'b1111 -> out_result=0, out_zero=1, out_illegal=1, tag preserved. Next legal op has out_illegal=0.
- Reset mid-stall: FULL state, assert rst=0 -> out_valid drops immediately (async). After release the buffer is empty and no stale tag appears.
